// File: rtl/flexbex_dmem_ctrl.sv
// flexbex_dmem_ctrl: two-master (ibex core / eFPGA) banked SRAM controller.
// Optional macro FLEXBEX_DMEM_RANGE_ERR_EN: out-of-range addresses return err.
module flexbex_dmem_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_AW   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [3:0]              core_be_i,
  input  logic [31:0]             core_addr_i,
  input  logic [31:0]             core_wdata_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic                    core_err_o,
  output logic [31:0]             core_rdata_o,
  input  logic                    fab_req_i,
  input  logic                    fab_we_i,
  input  logic [3:0]              fab_be_i,
  input  logic [31:0]             fab_addr_i,
  input  logic [31:0]             fab_wdata_i,
  output logic                    fab_gnt_o,
  output logic                    fab_rvalid_o,
  output logic                    fab_err_o,
  output logic [31:0]             fab_rdata_o,
  output logic [NUM_BANKS-1:0]    sram_csb_o,
  output logic                    sram_web_o,
  output logic [3:0]              sram_wmask_o,
  output logic [BANK_AW-1:0]      sram_addr_o,
  output logic [31:0]             sram_din_o,
  input  logic [NUM_BANKS*32-1:0] sram_dout_i
);

  localparam int LB  = $clog2(NUM_BANKS);
  localparam int BW  = (LB > 0) ? LB : 1;
  localparam int TOP = BANK_AW + LB + 2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_FAB  = 2'd2;

  logic          r_ptr;
  logic [1:0]    r_owner;
  logic [1:0]    w_owner_nxt;
  logic [BW-1:0] r_bank;
  logic [BW-1:0] w_bank;
  logic          r_err;
  logic          w_err;
  logic          r_rd;
  logic          w_gnt_core;
  logic          w_gnt_fab;
  logic          w_gnt;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_bsh;
  logic [31:0]   w_slice;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Round-robin grant (r_ptr=1 favours fab) and granted-request mux
  always_comb begin
    w_gnt_core = resetn & core_req_i & (~fab_req_i | ~r_ptr);
    w_gnt_fab  = resetn & fab_req_i & (~core_req_i | r_ptr);
    w_gnt      = w_gnt_core | w_gnt_fab;
    w_we       = w_gnt_fab ? fab_we_i    : core_we_i;
    w_be       = w_gnt_fab ? fab_be_i    : core_be_i;
    w_addr     = w_gnt_fab ? fab_addr_i  : core_addr_i;
    w_wdata    = w_gnt_fab ? fab_wdata_i : core_wdata_i;
  end

  assign core_gnt_o = w_gnt_core;
  assign fab_gnt_o  = w_gnt_fab;

  assign w_bsh  = w_addr >> (BANK_AW + 2);
  assign w_bank = w_bsh[BW-1:0] & BW'(NUM_BANKS - 1);

`ifdef FLEXBEX_DMEM_RANGE_ERR_EN
  assign w_err = |(w_addr >> TOP);
`else
  assign w_err = 1'b0;
`endif

  assign w_unused = ^{w_addr[1:0], w_bsh, r_err};

  // Pointer moves only when both masters competed for this grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= 1'b0;
    end else if (core_req_i & fab_req_i & w_gnt) begin
      r_ptr <= w_gnt_core;
    end
  end

  // Response owner state register plus captured bank/error/read flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= OWN_NONE;
      r_bank  <= '0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_bank  <= w_bank;
      r_err   <= w_gnt & w_err;
      r_rd    <= w_gnt & ~w_we & ~w_err;
    end
  end

  // Next owner: whoever is granted this cycle gets next cycle's response
  always_comb begin
    w_owner_nxt = OWN_NONE;
    unique case (1'b1)
      w_gnt_core: w_owner_nxt = OWN_CORE;
      w_gnt_fab:  w_owner_nxt = OWN_FAB;
      default:    w_owner_nxt = OWN_NONE;
    endcase
  end

  // SRAM strobes for the granted access; idle keeps all banks deselected
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      sram_csb_o[i] = ~(w_gnt & ~w_err & (w_bank == BW'(i)));
    end
    sram_web_o   = ~(w_gnt & w_we);
    sram_wmask_o = w_gnt ? w_be : 4'h0;
    sram_addr_o  = w_addr[BANK_AW+1:2];
    sram_din_o   = w_wdata;
  end

  // Response outputs steered to the owner only
  always_comb begin
    w_slice       = sram_dout_i[32*r_bank +: 32];
    w_rdata       = r_rd ? w_slice : 32'h0;
    core_rvalid_o = (r_owner == OWN_CORE);
    fab_rvalid_o  = (r_owner == OWN_FAB);
    core_rdata_o  = core_rvalid_o ? w_rdata : 32'h0;
    fab_rdata_o   = fab_rvalid_o  ? w_rdata : 32'h0;
`ifdef FLEXBEX_DMEM_RANGE_ERR_EN
    core_err_o    = core_rvalid_o & r_err;
    fab_err_o     = fab_rvalid_o  & r_err;
`else
    core_err_o    = 1'b0;
    fab_err_o     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_flexbex_dmem_ctrl.sv
// tb_flexbex_dmem_ctrl: random + directed bench against a flat-memory model.
// Honours FLEXBEX_DMEM_RANGE_ERR_EN the same way as the design build.
module tb_flexbex_dmem_ctrl;

  localparam int NB    = 4;
  localparam int AW    = 8;
  localparam int WORDS = NB * (1 << AW);

  logic          clk;
  logic          resetn;
  logic          core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [3:0]    core_be;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic          fab_req, fab_we, fab_gnt, fab_rvalid, fab_err;
  logic [3:0]    fab_be;
  logic [31:0]   fab_addr, fab_wdata, fab_rdata;
  logic [NB-1:0] sram_csb;
  logic          sram_web;
  logic [3:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din;
  logic [NB*32-1:0] sram_dout;

  flexbex_dmem_ctrl #(.NUM_BANKS(NB), .BANK_AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .core_err_o(core_err), .core_rdata_o(core_rdata),
    .fab_req_i(fab_req), .fab_we_i(fab_we), .fab_be_i(fab_be),
    .fab_addr_i(fab_addr), .fab_wdata_i(fab_wdata),
    .fab_gnt_o(fab_gnt), .fab_rvalid_o(fab_rvalid),
    .fab_err_o(fab_err), .fab_rdata_o(fab_rdata),
    .sram_csb_o(sram_csb), .sram_web_o(sram_web),
    .sram_wmask_o(sram_wmask), .sram_addr_o(sram_addr),
    .sram_din_o(sram_din), .sram_dout_i(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM bank stand-ins: registered read port, byte-masked write
  logic [31:0] bank_mem [NB][1<<AW];
  logic [31:0] dout_r [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!sram_csb[b]) begin
        if (!sram_web) begin
          for (int k = 0; k < 4; k++)
            if (sram_wmask[k])
              bank_mem[b][sram_addr][k*8 +: 8] <= sram_din[k*8 +: 8];
        end else begin
          dout_r[b] <= bank_mem[b][sram_addr];
        end
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_dout
    assign sram_dout[g*32 +: 32] = dout_r[g];
  end

  // Reference model: flat word memory, rr pointer, pending response
  logic [31:0] ref_mem [WORDS];
  int          m_ptr;
  int          p_owner;
  logic        p_err;
  logic [31:0] p_rdata;
  int          checks;
  int          failures;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  initial begin
    for (int b = 0; b < NB; b++) begin
      dout_r[b] = '0;
      for (int a = 0; a < (1 << AW); a++)
        bank_mem[b][a] = init_word(b * (1 << AW) + a);
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic cr, input logic cw, input logic [3:0] cb,
                      input logic [31:0] ca, input logic [31:0] cd,
                      input logic fr, input logic fw, input logic [3:0] fb,
                      input logic [31:0] fa, input logic [31:0] fd);
    int          w;
    logic        we;
    logic        oor;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] d;
    int unsigned widx;
    logic [31:0] ecsb;
    @(negedge clk);
    core_req = cr; core_we = cw; core_be = cb; core_addr = ca; core_wdata = cd;
    fab_req = fr; fab_we = fw; fab_be = fb; fab_addr = fa; fab_wdata = fd;
    #1;
    chk("core_rvalid", 32'(core_rvalid), 32'(p_owner == 1));
    chk("fab_rvalid", 32'(fab_rvalid), 32'(p_owner == 2));
    chk("core_rdata", core_rdata, (p_owner == 1) ? p_rdata : 32'h0);
    chk("fab_rdata", fab_rdata, (p_owner == 2) ? p_rdata : 32'h0);
    chk("core_err", 32'(core_err), 32'(p_owner == 1 && p_err));
    chk("fab_err", 32'(fab_err), 32'(p_owner == 2 && p_err));
    w = 0;
    if (cr && fr) begin
      w = (m_ptr == 0) ? 1 : 2;
      m_ptr = (w == 1) ? 1 : 0;
    end else if (cr) w = 1;
    else if (fr) w = 2;
    chk("core_gnt", 32'(core_gnt), 32'(w == 1));
    chk("fab_gnt", 32'(fab_gnt), 32'(w == 2));
    if (w != 0) begin
      we = (w == 1) ? cw : fw;
      be = (w == 1) ? cb : fb;
      a  = (w == 1) ? ca : fa;
      d  = (w == 1) ? cd : fd;
`ifdef FLEXBEX_DMEM_RANGE_ERR_EN
      oor = (a >= 32'(WORDS * 4));
`else
      oor = 1'b0;
`endif
      widx = (a >> 2) % WORDS;
      ecsb = oor ? 32'hF : (32'hF & ~(32'h1 << (widx / (1 << AW))));
      chk("csb", 32'(sram_csb), ecsb);
      chk("web", 32'(sram_web), 32'(!we));
      chk("wmask", 32'(sram_wmask), 32'(be));
      if (!oor) chk("addr", 32'(sram_addr), widx % (1 << AW));
      if (we) chk("din", sram_din, d);
      p_owner = w;
      p_err   = oor;
      p_rdata = (we || oor) ? 32'h0 : ref_mem[widx];
      if (we && !oor)
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[widx][k*8 +: 8] = d[k*8 +: 8];
    end else begin
      chk("csb_idle", 32'(sram_csb), 32'hF);
      chk("web_idle", 32'(sram_web), 32'h1);
      chk("wmask_idle", 32'(sram_wmask), 32'h0);
      p_owner = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    core_req = 1'b1; fab_req = 1'b1;
    #1;
    chk("rst_core_gnt", 32'(core_gnt), 32'h0);
    chk("rst_fab_gnt", 32'(fab_gnt), 32'h0);
    chk("rst_csb", 32'(sram_csb), 32'hF);
    chk("rst_core_rvalid", 32'(core_rvalid), 32'h0);
    chk("rst_fab_rvalid", 32'(fab_rvalid), 32'h0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_fab_rdata", fab_rdata, 32'h0);
    chk("rst_err", 32'({core_err, fab_err}), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    core_req = 1'b0; fab_req = 1'b0;
    m_ptr = 0;
    p_owner = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom % 8;
    if (r == 0) return 32'h1000 + ($urandom % 64) * 4;
    if (r == 1) return $urandom;
    return (((($urandom % NB) << AW) + ($urandom % 8)) << 2) | ($urandom % 4);
  endfunction

  initial begin
    checks = 0; failures = 0;
    m_ptr = 0; p_owner = 0; p_err = 0; p_rdata = 0;
    resetn = 1'b0;
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    fab_req = 0; fab_we = 0; fab_be = 0; fab_addr = 0; fab_wdata = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // core write then read of 0x104
    step(1, 1, 4'hF, 32'h104, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 0, 4'hF, 32'h104, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();
    chk("wr_rd_mem", ref_mem[32'h104 >> 2], 32'hDEADBEEF);

    // fab read from bank 3 word 0
    step(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'hC00, 32'h0);
    step(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'hC00, 32'h0);
    idle();

    // first word past the end of memory
    step(1, 0, 4'hF, 32'h1000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();

    // single-byte write
    step(1, 1, 4'b0010, 32'h8, 32'h0000_5A00, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();

    // both masters every cycle: alternating grants, back-to-back
    for (int i = 0; i < 4; i++)
      step(1, 0, 4'hF, 32'h100 + 32'(i * 4), 32'h0,
           1, 0, 4'hF, 32'h400 + 32'(i * 4), 32'h0);
    idle();

    // reset mid-response: pending response dropped, pointer to core
    step(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0);
    do_reset();
    step(1, 0, 4'hF, 32'h30, 32'h0, 1, 0, 4'hF, 32'h40, 32'h0);
    idle();

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, $urandom % 2, 4'($urandom), rnd_addr(), $urandom,
           $urandom % 4 != 0, $urandom % 2, 4'($urandom), rnd_addr(), $urandom);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flexbex_dmem_ctrl.md
FLEXBEX_DMEM_CTRL -- requirements
Module: flexbex_dmem_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of sram_1rw1r_32_256_8_sky130 banks (power of two, 1..8).
REQ-002 SHALL have parameter BANK_AW, default 8: word-address width per bank.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports core_req_i / core_we_i / core_be_i, input, 1 / 1 / 4: ibex data request, write enable, byte enables.
REQ-006 SHALL have ports core_addr_i / core_wdata_i, input, 32 / 32: byte address and write data.
REQ-007 SHALL have ports core_gnt_o / core_rvalid_o / core_err_o, output, 1 each: grant, response valid, response error.
REQ-008 SHALL have port core_rdata_o, output, 32: read data.
REQ-009 SHALL have fab_req_i, fab_we_i, fab_be_i, fab_addr_i, fab_wdata_i, fab_gnt_o, fab_rvalid_o, fab_err_o, fab_rdata_o: eFPGA master port, same widths and meaning as core_*.
REQ-010 SHALL have port sram_csb_o, output, NUM_BANKS: per-bank active-low chip select.
REQ-011 SHALL have ports sram_web_o / sram_wmask_o, output, 1 / 4: shared active-low write enable and write mask.
REQ-012 SHALL have ports sram_addr_o / sram_din_o, output, BANK_AW / 32: shared bank word address and write data.
REQ-013 SHALL have port sram_dout_i, input, NUM_BANKS*32: concatenated bank read data, bank 0 in LSBs.

Function
REQ-014 SHALL decode word index = addr[BANK_AW+log2(NUM_BANKS)+1:2]; bank = upper log2(NUM_BANKS) bits of it; sram_addr_o = lower BANK_AW bits.
REQ-015 SHALL grant at most one master per cycle; gnt is combinational, asserted in the same cycle as the granted req.
REQ-016 SHALL arbitrate round-robin: pointer initialised to core; pointer passes to the other master only after a grant issued while both masters requested.
REQ-017 SHALL assert exactly one sram_csb_o bit low in the grant cycle for an in-range access; all bits high otherwise.
REQ-018 SHALL drive sram_web_o = ~we and sram_wmask_o = be of the granted master; sram_web_o high and mask 0 when idle.
REQ-019 SHALL register owner (NONE/CORE/FAB), bank and error flag at grant; rvalid to that owner exactly one cycle after grant, for reads and writes.
REQ-020 SHALL return rdata = selected bank slice of sram_dout_i for reads; 0 for writes and errors; rdata to the non-owner master is 0.
REQ-021 SHALL support back-to-back grants every cycle (grant in cycle N+1 while rvalid of cycle N is active); no bubble.
REQ-022 SHALL never assert rvalid to both masters in one cycle, nor without a preceding grant.

Reset
REQ-023 SHALL on resetn low, asynchronously: owner NONE, all rvalid/err 0, rdata 0, sram_csb_o all 1, round-robin pointer to core.
REQ-024 SHALL drop a pending response when reset asserts mid-transaction; no rvalid after reset release until a new grant.
REQ-025 SHALL gate gnt outputs low while resetn is low.

Configuration
REQ-026 SHALL implement macro FLEXBEX_DMEM_RANGE_ERR_EN.
REQ-027 With FLEXBEX_DMEM_RANGE_ERR_EN defined: an address >= NUM_BANKS*2^BANK_AW*4 is granted, no csb asserted, rvalid next cycle with err=1, rdata=0.
REQ-028 Without FLEXBEX_DMEM_RANGE_ERR_EN: upper address bits ignored (accesses wrap modulo memory size); core_err_o and fab_err_o tied 0.

Verification
REQ-029 Core write 0xDEADBEEF to 0x0000_0104, be=4'hF, then read same -> gnt same cycle each, rvalid +1 cycle each, read data 0xDEADBEEF, csb bit 0 low.
REQ-030 Core and fab request simultaneously every cycle for 4 cycles -> grants alternate core, fab, core, fab; one rvalid per cycle to matching master.
REQ-031 NUM_BANKS=4, BANK_AW=8: fab read 0x0000_0C00 -> sram_csb_o=4'b0111, sram_addr_o=0x00, rdata from bank 3 slice.
REQ-032 Read 0x0000_1000 with FLEXBEX_DMEM_RANGE_ERR_EN -> csb all 1, rvalid+err=1, rdata 0; without macro -> bank 0 addr 0 accessed, err 0.
REQ-033 Byte write be=4'b0010 to 0x0000_0008 -> sram_wmask_o=4'b0010, sram_web_o=0 in grant cycle.
REQ-034 resetn pulsed low in cycle after a grant -> no rvalid produced; pointer back to core; next simultaneous request granted to core.
